seg7_scan_mux: RTL and testbench

//  Parametrised multiplexed seven-segment driver for the board dashboard; successor to the fixed 8-digit scanner.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_decode.sv | 19 +
 rtl/seg7_scan_mux.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_mux.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high gfedcba pattern for one hex nibble
  function automatic logic [6:0] seg7_hex(input logic [3:0] nibble);
    case (nibble)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble + decimal point + blank to active-high {dp,g,f,e,d,c,b,a}.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = '0;
    if (!blank_i) begin
      seg_o[SEG_G:SEG_A] = seg7_hex(nibble_i);
      seg_o[SEG_DP]      = dp_i;
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed seven-segment scanner with guard band, PWM dimming and
// frame-synchronous commit of shadowed display data.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int GUARD      = 64,
  parameter int BRIGHT_W   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic [BRIGHT_W-1:0]   bright_i,
  input  logic                  load_i,
  output logic [DIGITS-1:0]     anodes_o,
  output logic [7:0]            cathodes_o,
  output logic                  frame_tick_o
);

  localparam int IDX_W = idx_w(DIGITS);
  localparam int PRE_W = idx_w(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] GUARD_V  = PRE_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic                pending_q, pending_d;
  logic [4*DIGITS-1:0] sh_val_q, sh_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d, disp_blank_q, disp_blank_d;
  logic [DIGITS-1:0]   anodes_q, anodes_d, an_on;
  logic [7:0]          cathodes_q, cathodes_d, seg_raw;
  logic                frame_tick_q, frame_tick_d;
  logic                last_slot, tick_now, on_window;
  logic [3:0]          nib_sel;
  logic                dp_sel, blank_sel;

  always_comb begin
    last_slot = (presc_q == PRE_LAST);
    tick_now  = last_slot && (idx_q == IDX_LAST);
    presc_d   = last_slot ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    if (last_slot) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    pwm_d     = pwm_q + 1'b1;

    sh_val_d   = load_i ? value_i : sh_val_q;
    sh_dp_d    = load_i ? dp_i    : sh_dp_q;
    sh_blank_d = load_i ? blank_i : sh_blank_q;
    pending_d  = pending_q | load_i;

    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    // Display data only ever changes at the frame boundary; a load on that
    // very cycle bypasses the shadow so it is not deferred a whole frame.
    if (tick_now) begin
      if (load_i) begin
        disp_val_d   = value_i;
        disp_dp_d    = dp_i;
        disp_blank_d = blank_i;
      end else if (pending_q) begin
        disp_val_d   = sh_val_q;
        disp_dp_d    = sh_dp_q;
        disp_blank_d = sh_blank_q;
      end
      pending_d = 1'b0;
    end
  end

  // Outputs are computed from next-state values so the registered pins line
  // up with the counters after the same edge.
  always_comb begin
    on_window = (presc_d >= GUARD_V) && (pwm_d <= bright_i);
    nib_sel   = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b1;
    an_on     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib_sel   = disp_val_d[4*i +: 4];
        dp_sel    = disp_dp_d[i];
        blank_sel = disp_blank_d[i];
        an_on[i]  = on_window && !disp_blank_d[i];
      end
    end
    anodes_d     = an_on ^ {DIGITS{POL}};
    cathodes_d   = seg_raw ^ {8{POL}};
    frame_tick_d = (presc_d == PRE_LAST) && (idx_d == IDX_LAST);
  end

  seg7_decode u_decode (
    .nibble_i (nib_sel),
    .dp_i     (dp_sel),
    .blank_i  (blank_sel),
    .seg_o    (seg_raw)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      pending_q    <= 1'b0;
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '1;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      anodes_q     <= {DIGITS{POL}};
      cathodes_q   <= {8{POL}};
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      pending_q    <= pending_d;
      sh_val_q     <= sh_val_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      anodes_q     <= anodes_d;
      cathodes_q   <= cathodes_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign anodes_o     = anodes_q;
  assign cathodes_o   = cathodes_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with DIGITS=4, SCAN_DIV=8, GUARD=2, BRIGHT_W=2, active-low pins.
module tb_seg7_scan_mux;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic [3:0]  blank_i;
  logic [1:0]  bright_i;
  logic        load_i;
  logic [3:0]  anodes_o;
  logic [7:0]  cathodes_o;
  logic        frame_tick_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  seg7_scan_mux #(
    .DIGITS(4), .SCAN_DIV(8), .GUARD(2), .BRIGHT_W(2), .ACTIVE_LOW(1)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .value_i      (value_i),
    .dp_i         (dp_i),
    .blank_i      (blank_i),
    .bright_i     (bright_i),
    .load_i       (load_i),
    .anodes_o     (anodes_o),
    .cathodes_o   (cathodes_o),
    .frame_tick_o (frame_tick_o)
  );

  // Returns at the negedge inside the frame_tick cycle, or with found=0.
  task automatic wait_tick(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_i);
      if (frame_tick_o === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    int ticks;
    rst_n_i = 1'b0;
    repeat (5) @(negedge clk_i);
    checks++;
    if (anodes_o !== 4'hF) begin errors++; $display("FAIL reset_anodes got=%h exp=F", anodes_o); end
    checks++;
    if (cathodes_o !== 8'hFF) begin errors++; $display("FAIL reset_cathodes got=%h exp=FF", cathodes_o); end
    checks++;
    if (frame_tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", frame_tick_o); end
    rst_n_i = 1'b1;
    ticks = 0;
    for (int k = 1; k <= 96; k++) begin
      @(negedge clk_i);
      checks++;
      if (anodes_o !== 4'hF || cathodes_o !== 8'hFF) begin
        errors++;
        $display("FAIL dark_after_reset k=%0d anodes=%h cathodes=%h exp=F/FF", k, anodes_o, cathodes_o);
      end
      if (frame_tick_o === 1'b1) begin
        ticks++;
        checks++;
        if (k % 32 != 31) begin errors++; $display("FAIL first_tick_pos k=%0d exp k%%32==31", k); end
      end
    end
    checks++;
    if (ticks != 3) begin errors++; $display("FAIL tick_count_3frames got=%0d exp=3", ticks); end
  endtask

  task automatic test_load_commit;
    bit found;
    int presc, idx;
    logic [3:0] exp_an;
    logic [7:0] cath_tab [4] = '{8'h19, 8'hB0, 8'hA4, 8'hF9};
    value_i = 16'h1234; dp_i = 4'b0001; blank_i = 4'b0000; bright_i = 2'd3; load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_i);
      checks++;
      if (anodes_o !== 4'hF || cathodes_o !== 8'hFF) begin
        errors++;
        $display("FAIL early_commit anodes=%h cathodes=%h exp=F/FF", anodes_o, cathodes_o);
      end
      if (frame_tick_o === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL commit_tick_timeout got=none exp=tick"); end
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_i);
      presc = (k - 1) % 8;
      idx   = (k - 1) / 8;
      exp_an = (presc >= 2) ? ~(4'b0001 << idx) : 4'hF;
      checks++;
      if (anodes_o !== exp_an || cathodes_o !== cath_tab[idx] || frame_tick_o !== (k == 32)) begin
        errors++;
        $display("FAIL frame_1234 k=%0d got an=%h cat=%h tick=%b exp an=%h cat=%h tick=%b",
                 k, anodes_o, cathodes_o, frame_tick_o, exp_an, cath_tab[idx], (k == 32));
      end
    end
  endtask

  task automatic test_scan;
    int ticks;
    logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    ticks = 0;
    for (int k = 1; k <= 96; k++) begin
      @(negedge clk_i);
      if (k % 8 == 3) begin
        checks++;
        if (anodes_o !== an_seq[(k / 8) % 4]) begin
          errors++;
          $display("FAIL index_seq k=%0d got=%h exp=%h", k, anodes_o, an_seq[(k / 8) % 4]);
        end
      end
      if (frame_tick_o === 1'b1) begin
        ticks++;
        checks++;
        if (k % 32 != 0) begin errors++; $display("FAIL tick_period k=%0d exp multiple of 32", k); end
      end
    end
    checks++;
    if (ticks != 3) begin errors++; $display("FAIL tick_count got=%0d exp=3", ticks); end
  endtask

  task automatic test_last_load_wins;
    bit found;
    logic [7:0] cath_tab [4] = '{8'h86, 8'hA1, 8'hC0, 8'hC6};
    repeat (5) @(negedge clk_i);
    value_i = 16'hAAAA; dp_i = 4'b0000; blank_i = 4'b0000; load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
    repeat (8) @(negedge clk_i);
    value_i = 16'hBBBB; load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
    repeat (13) @(negedge clk_i);
    checks++;
    if (anodes_o !== 4'h7 || cathodes_o !== 8'hF9) begin
      errors++;
      $display("FAIL no_midframe_change got an=%h cat=%h exp an=7 cat=F9", anodes_o, cathodes_o);
    end
    wait_tick(10, found);
    checks++;
    if (!found) begin errors++; $display("FAIL bbbb_tick_timeout got=none exp=tick"); end
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_i);
      checks++;
      if (cathodes_o !== 8'h83) begin
        errors++;
        $display("FAIL last_load_wins k=%0d got=%h exp=83", k, cathodes_o);
      end
    end
    checks++;
    if (frame_tick_o !== 1'b1) begin errors++; $display("FAIL bbbb_frame_end_tick got=%b exp=1", frame_tick_o); end
    value_i = 16'hC0DE; load_i = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_i);
      if (k == 1) load_i = 1'b0;
      checks++;
      if (cathodes_o !== cath_tab[(k - 1) / 8]) begin
        errors++;
        $display("FAIL load_on_tick k=%0d got=%h exp=%h", k, cathodes_o, cath_tab[(k - 1) / 8]);
      end
    end
  endtask

  task automatic test_brightness_blank;
    int presc, idx;
    logic [7:0] mask;
    logic [3:0] exp_an;
    logic [7:0] cath_tab [4] = '{8'h99, 8'hB0, 8'hFF, 8'hF9};
    value_i = 16'h1234; dp_i = 4'b0000; blank_i = 4'b0100; bright_i = 2'd0; load_i = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk_i);
      if (k == 1) load_i = 1'b0;
      presc = (k - 1) % 8;
      idx   = ((k - 1) / 8) % 4;
      mask  = (k <= 32) ? 8'b0001_0000 : 8'b0111_0100;
      exp_an = (mask[presc] && idx != 2) ? ~(4'b0001 << idx) : 4'hF;
      checks++;
      if (anodes_o !== exp_an || cathodes_o !== cath_tab[idx]) begin
        errors++;
        $display("FAIL bright_blank k=%0d got an=%h cat=%h exp an=%h cat=%h",
                 k, anodes_o, cathodes_o, exp_an, cath_tab[idx]);
      end
      if (k == 32) bright_i = 2'd2;
    end
  endtask

  task automatic test_reset_mid_slot;
    bit found;
    bright_i = 2'd3;
    value_i = 16'h5678; dp_i = 4'b0000; blank_i = 4'b0000; load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
    repeat (2) @(negedge clk_i);
    value_i = 16'h9ABC; load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
    repeat (15) @(negedge clk_i);
    checks++;
    if (anodes_o !== 4'hB || cathodes_o !== 8'h82) begin
      errors++;
      $display("FAIL pre_reset_slot2 got an=%h cat=%h exp an=B cat=82", anodes_o, cathodes_o);
    end
    rst_n_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (anodes_o !== 4'hF || cathodes_o !== 8'hFF || frame_tick_o !== 1'b0) begin
      errors++;
      $display("FAIL midslot_reset got an=%h cat=%h tick=%b exp F/FF/0", anodes_o, cathodes_o, frame_tick_o);
    end
    rst_n_i = 1'b1;
    found = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      @(negedge clk_i);
      checks++;
      if (anodes_o !== 4'hF || cathodes_o !== 8'hFF) begin
        errors++;
        $display("FAIL pending_cleared k=%0d got an=%h cat=%h exp F/FF", k, anodes_o, cathodes_o);
      end
      if (frame_tick_o === 1'b1 && !found) begin
        found = 1'b1;
        checks++;
        if (k != 31) begin errors++; $display("FAIL restart_digit0 tick at k=%0d exp k=31", k); end
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL post_reset_tick_timeout got=none exp=tick"); end
  endtask

  initial begin
    rst_n_i  = 1'b0;
    value_i  = '0;
    dp_i     = '0;
    blank_i  = '0;
    bright_i = 2'd3;
    load_i   = 1'b0;
    test_reset;
    test_load_commit;
    test_scan;
    test_last_load_wins;
    test_brightness_blank;
    test_reset_mid_slot;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
